// File: rtl/keymap_pkg.sv
// Shared types and constants for the PS/2 scancode to MSX key-matrix controller.
package keymap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SKIP   = 2'd3
  } state_t;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  localparam int MAP_UNMAPPED_BIT = 7;
  localparam int ROW_LSB          = 0;
  localparam int ROW_W            = 4;
  localparam int COL_LSB          = 4;
  localparam int COL_W            = 3;
  localparam int DEFAULT_NUM_ROWS = 11;

  function automatic logic [ROW_W-1:0] map_row(input logic [7:0] m);
    return m[ROW_LSB +: ROW_W];
  endfunction

  function automatic logic [COL_W-1:0] map_col(input logic [7:0] m);
    return m[COL_LSB +: COL_W];
  endfunction

endpackage

// File: rtl/keymap_matrix.sv
// MSX key matrix: NUM_ROWS x 8 bits, active-low, one bit-write port and a
// registered row read port. Rows at or above NUM_ROWS read as all released.
import keymap_pkg::*;

module keymap_matrix #(
  parameter int NUM_ROWS = DEFAULT_NUM_ROWS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic             wr_val,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_data
);

  logic [7:0] mat [NUM_ROWS];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_ROWS; r++) mat[r] <= 8'hFF;
      rd_data <= 8'hFF;
    end else begin
      if (wr_en && (int'(wr_row) < NUM_ROWS)) mat[wr_row][wr_col] <= wr_val;
      rd_data <= (int'(rd_row) < NUM_ROWS) ? mat[rd_row] : 8'hFF;
    end
  end

endmodule

// File: rtl/ps2_keymap_ctrl.sv
// PS/2 scancode to MSX matrix controller: prefix tracking, map RAM lookup and
// matrix update. Optional pause-sequence skipping under KEYMAP_PAUSE_SKIP_EN.
import keymap_pkg::*;

module ps2_keymap_ctrl #(
  parameter int NUM_ROWS = DEFAULT_NUM_ROWS,
  parameter int SKIP_LEN = 7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       ready,
  output logic       overrun,
  output logic [8:0] map_addr,
  input  logic [7:0] map_q,
  input  logic [3:0] row_sel,
  output logic [7:0] row_data
);

  // Row field is 4 bits wide and the pause counter must be able to count.
  if (NUM_ROWS < 1 || NUM_ROWS > 16 || SKIP_LEN < 1) begin : g_param_check
    $error("ps2_keymap_ctrl: NUM_ROWS must be 1..16 and SKIP_LEN >= 1");
  end

  state_t           state;
  logic             ext;
  logic             brk;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;

`ifdef KEYMAP_PAUSE_SKIP_EN
  localparam int SKIP_W = $clog2(SKIP_LEN + 1);
  logic [SKIP_W-1:0] skip_cnt;
`endif

  assign wr_row = map_row(map_q);
  assign wr_col = map_col(map_q);
  assign wr_en  = (state == ST_APPLY) && !map_q[MAP_UNMAPPED_BIT] &&
                  (int'(wr_row) < NUM_ROWS);

  // ready is a registered copy of "state accepts bytes" (IDLE, or SKIP)
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ext      <= 1'b0;
      brk      <= 1'b0;
      ready    <= 1'b1;
      overrun  <= 1'b0;
      map_addr <= '0;
`ifdef KEYMAP_PAUSE_SKIP_EN
      skip_cnt <= '0;
`endif
    end else begin
      if (scan_valid && !ready) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (scan_valid) begin
            if (scan_code == PFX_EXT) begin
              ext <= 1'b1;
            end else if (scan_code == PFX_BRK) begin
              brk <= 1'b1;
`ifdef KEYMAP_PAUSE_SKIP_EN
            end else if (scan_code == PFX_PAUSE) begin
              skip_cnt <= SKIP_W'(SKIP_LEN);
              state    <= ST_SKIP;
`endif
            end else begin
              map_addr <= {ext, scan_code};
              state    <= ST_LOOKUP;
              ready    <= 1'b0;
            end
          end
        end
        ST_LOOKUP: state <= ST_APPLY;
        ST_APPLY: begin
          ext   <= 1'b0;
          brk   <= 1'b0;
          state <= ST_IDLE;
          ready <= 1'b1;
        end
`ifdef KEYMAP_PAUSE_SKIP_EN
        ST_SKIP: begin
          if (scan_valid) begin
            if (skip_cnt <= SKIP_W'(1)) begin
              skip_cnt <= '0;
              ext      <= 1'b0;
              brk      <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              skip_cnt <= skip_cnt - SKIP_W'(1);
            end
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  keymap_matrix #(
    .NUM_ROWS (NUM_ROWS)
  ) u_matrix (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_val  (brk),
    .rd_row  (row_sel),
    .rd_data (row_data)
  );

endmodule

// File: tb/tb_ps2_keymap_ctrl.sv
// Self-checking bench for ps2_keymap_ctrl with a behavioural key-matrix model.
`timescale 1ns/1ps

module tb_ps2_keymap_ctrl;

  localparam int NROWS = 11;
  localparam int SKIPN = 7;

  logic       clock;
  logic       reset_n;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       ready;
  logic       overrun;
  logic [8:0] map_addr;
  logic [7:0] map_q;
  logic [3:0] row_sel;
  logic [7:0] row_data;

  logic [7:0] map_mem [512];

  logic [7:0] ref_mat [16];
  logic       ref_ext;
  logic       ref_brk;
  logic       ref_ovr;
  int         ref_skip;

  int checks = 0;
  int errors = 0;

  ps2_keymap_ctrl #(
    .NUM_ROWS (NROWS),
    .SKIP_LEN (SKIPN)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .ready      (ready),
    .overrun    (overrun),
    .map_addr   (map_addr),
    .map_q      (map_q),
    .row_sel    (row_sel),
    .row_data   (row_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous map RAM: data one cycle after the address.
  always @(posedge clock) map_q <= map_mem[map_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_row(input logic [3:0] r);
    return (int'(r) < NROWS) ? ref_mat[r] : 8'hFF;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++) ref_mat[r] = 8'hFF;
    ref_ext  = 1'b0;
    ref_brk  = 1'b0;
    ref_ovr  = 1'b0;
    ref_skip = 0;
  endtask

  // Effect of one accepted byte; reports whether a map lookup happens.
  task automatic model_byte(input logic [7:0] c, output logic lookup, output logic [8:0] addr);
    logic [7:0] m;
    lookup = 1'b0;
    addr   = '0;
`ifdef KEYMAP_PAUSE_SKIP_EN
    if (ref_skip > 0) begin
      ref_skip--;
      if (ref_skip == 0) begin
        ref_ext = 1'b0;
        ref_brk = 1'b0;
      end
      return;
    end
    if (c == 8'hE1) begin
      ref_skip = SKIPN;
      return;
    end
`endif
    if (c == 8'hE0) ref_ext = 1'b1;
    else if (c == 8'hF0) ref_brk = 1'b1;
    else begin
      lookup = 1'b1;
      addr   = {ref_ext, c};
      m      = map_mem[addr];
      if (!m[7] && int'(m[3:0]) < NROWS) ref_mat[m[3:0]][m[6:4]] = ref_brk;
      ref_ext = 1'b0;
      ref_brk = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", ready, 1);
  endtask

  // Called and returns at a falling edge; checks lookup timing N+1..N+4.
  task automatic send_byte(input logic [7:0] c);
    logic       lk;
    logic [8:0] a;
    logic [7:0] old_row;
    wait_ready();
    old_row    = exp_row(row_sel);
    scan_valid = 1'b1;
    scan_code  = c;
    model_byte(c, lk, a);
    @(negedge clock);
    scan_valid = 1'b0;
    if (lk) begin
      chk("lookup_addr", map_addr, a);
      chk("lookup_busy", ready, 0);
      @(negedge clock);
      chk("apply_addr", map_addr, a);
      chk("apply_busy", ready, 0);
      @(negedge clock);
      chk("ready_n3", ready, 1);
      chk("row_n3_old", row_data, old_row);
      @(negedge clock);
      chk("row_n4_new", row_data, exp_row(row_sel));
    end else begin
      chk("prefix_ready", ready, 1);
    end
  endtask

  task automatic set_row(input logic [3:0] r);
    @(negedge clock);
    row_sel = r;
    @(negedge clock);
  endtask

  task automatic chk_rows();
    for (int r = 0; r < 16; r++) begin
      @(negedge clock);
      row_sel = 4'(r);
      @(negedge clock);
      chk($sformatf("row%0d", r), row_data, exp_row(4'(r)));
    end
    chk("overrun_state", overrun, ref_ovr);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    chk("rst_ready", ready, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_map_addr", map_addr, 0);
    chk("rst_row_data", row_data, 8'hFF);
  endtask

  logic       lk;
  logic [8:0] ad;
  logic [7:0] rb;
  logic [7:0] pause_seq [8];

  initial begin
    for (int a = 0; a < 512; a++) map_mem[a] = 8'h80;
    map_mem[9'h01C] = 8'h24;
    map_mem[9'h01B] = 8'h31;
    map_mem[9'h175] = 8'h58;
    map_mem[9'h075] = 8'h80;
    map_mem[9'h02A] = 8'h0B;
    map_mem[9'h014] = 8'h16;
    map_mem[9'h077] = 8'h47;
    map_mem[9'h0E1] = 8'h80;
    model_reset();
    reset_n    = 1'b0;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    row_sel    = 4'd0;
    repeat (3) @(negedge clock);
    chk("reset_ready", ready, 1);
    chk("reset_overrun", overrun, 0);
    chk("reset_map_addr", map_addr, 0);
    chk("reset_row_data", row_data, 8'hFF);
    reset_n = 1'b1;
    @(negedge clock);

    // make / break on row 4 col 2
    set_row(4'd4);
    send_byte(8'h1C);
    chk("make_row4", row_data, 8'hFB);
    send_byte(8'h1C);
    chk("typematic_row4", row_data, 8'hFB);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("break_row4", row_data, 8'hFF);

    // extended key on row 8 col 5; the plain code is unmapped
    set_row(4'd8);
    send_byte(8'hE0);
    send_byte(8'h75);
    chk("ext_row8", row_data, 8'hDF);
    send_byte(8'h75);
    chk("plain_75_addr", map_addr, 9'h075);
    chk("plain_75_row8", row_data, 8'hDF);
    chk_rows();

    // map byte points at a row beyond the matrix
    send_byte(8'h2A);
    set_row(4'd12);
    chk("row12_ff", row_data, 8'hFF);
    chk_rows();

    // pause sequence
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
    chk_rows();
    set_row(4'd4);
    send_byte(8'h1C);
    chk("after_pause_row4", row_data, 8'hFB);

    // overrun: second byte lands during LOOKUP and is dropped
    send_byte(8'hF0);
    send_byte(8'h1C);
    wait_ready();
    scan_valid = 1'b1;
    scan_code  = 8'h1C;
    model_byte(8'h1C, lk, ad);
    @(negedge clock);
    scan_code = 8'h1B;
    ref_ovr   = 1'b1;
    @(negedge clock);
    scan_valid = 1'b0;
    chk("overrun_set", overrun, 1);
    chk("overrun_addr", map_addr, 9'h01C);
    chk_rows();
    send_byte(8'h1B);
    chk("overrun_sticky", overrun, 1);

    // reset during APPLY of a make: key discarded, matrix released
    wait_ready();
    scan_valid = 1'b1;
    scan_code  = 8'h1C;
    @(negedge clock);
    scan_valid = 1'b0;
    @(negedge clock);
    pulse_reset();
    chk_rows();

    // stale ext prefix must not survive reset
    send_byte(8'hE0);
    pulse_reset();
    set_row(4'd8);
    send_byte(8'h75);
    chk("no_stale_ext", row_data, 8'hFF);

    // randomized map contents and key traffic
    for (int a = 0; a < 64; a++) begin
      rb = 8'($urandom);
      if ($urandom_range(3) != 0) rb[7] = 1'b0;
      map_mem[a] = rb;
      rb = 8'($urandom);
      if ($urandom_range(3) != 0) rb[7] = 1'b0;
      map_mem[256 + a] = rb;
    end
    for (int i = 0; i < 60; i++) begin
      set_row(4'($urandom_range(15)));
      if ($urandom_range(2) == 0) send_byte(8'hE0);
      if ($urandom_range(1) == 0) send_byte(8'hF0);
      send_byte(8'($urandom_range(63)));
      if (i % 6 == 5) chk_rows();
    end
    chk_rows();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
